// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants, channel index type and divisor helper for tick_gen_multi
package tick_gen_pkg;
  localparam int unsigned CLK_FREQ = 12090000;
  localparam int unsigned DIV_W = 24;
  localparam int unsigned MAX_CH = 16;
  typedef logic [3:0] ch_idx_t;
  function automatic logic [DIV_W-1:0] div_of(input int unsigned freq_hz);
    return freq_hz == 0 ? '0 : DIV_W'((64'(CLK_FREQ) + 64'(freq_hz / 2)) / 64'(freq_hz));
  endfunction
endpackage

// File: rtl/tick_gen_ch.sv
// tick_gen_ch: one divider channel with active/shadow divisor, tick strobe and square wave
//   clk_i, rst_ni      clock, async active-low reset
//   wr_i, div_i        divisor write strobe and value (0 disables the channel)
//   sync_i             phase restart, present only with TICKGEN_SYNC_EN
//   tick_o, sq_o       one-cycle strobe after terminal count, square wave
//   pend_o             shadow divisor waiting for the next terminal count
module tick_gen_ch import tick_gen_pkg::*; #(
  parameter int unsigned DIV_W = tick_gen_pkg::DIV_W,
  parameter logic [DIV_W-1:0] INIT = '0
) (
  input  logic clk_i, rst_ni, wr_i,
  input  logic [DIV_W-1:0] div_i,
`ifdef TICKGEN_SYNC_EN
  input  logic sync_i,
`endif
  output logic tick_o, sq_o, pend_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, shd_q, shd_d;
  logic pend_q, pend_d, tick_q, tick_d, sq_q, sq_d, en, tc, sync;
  assign en = act_q != '0;
  assign tc = en && cnt_q == act_q - DIV_W'(1);
`ifdef TICKGEN_SYNC_EN
  assign sync = sync_i && en;
`else
  assign sync = 1'b0;
`endif
  // A disabled channel has no terminal count to wait for, so a write (or a
  // shadow left pending when the channel disabled itself) goes live at once.
  always_comb begin
    cnt_d  = en && !tc && !sync ? cnt_q + DIV_W'(1) : '0;
    act_d  = wr_i && !en ? div_i : (tc || sync || (!en && pend_q) ? shd_q : act_q);
    shd_d  = wr_i ? div_i : shd_q;
    pend_d = wr_i ? en : (tc || sync || !en ? 1'b0 : pend_q);
    tick_d = tc && !sync;
    sq_d   = en && !sync && cnt_q < (act_q >> 1);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      cnt_q  <= '0;
      act_q  <= INIT;
      shd_q  <= INIT;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  assign tick_o = tick_q;
  assign sq_o   = sq_q;
  assign pend_o = pend_q;
endmodule

// File: rtl/tick_gen_multi.sv
// tick_gen_multi: N-channel clock-enable generator with runtime-reprogrammable divisors
//   clk_In, rst_n          system clock, async active-low reset
//   wr_en, wr_ch, wr_div   divisor write; wr_ch >= NUM_CH is ignored
//   sync_in                phase restart of all enabled channels (TICKGEN_SYNC_EN only)
//   tick_o, sq_o, pend_o   per-channel strobe, square wave, pending-write flag
module tick_gen_multi import tick_gen_pkg::*; #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DIV_W = tick_gen_pkg::DIV_W,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = {24'd12090000, 24'd403000, 24'd302250, 24'd48}
) (
  input  logic clk_In, rst_n, wr_en,
  input  ch_idx_t wr_ch,
  input  logic [DIV_W-1:0] wr_div,
`ifdef TICKGEN_SYNC_EN
  input  logic sync_in,
`endif
  output logic [NUM_CH-1:0] tick_o, sq_o, pend_o
);
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tick_gen_ch #(.DIV_W(DIV_W), .INIT(DIV_INIT[i*DIV_W +: DIV_W])) u_ch (
      .clk_i(clk_In),
      .rst_ni(rst_n),
      .wr_i(wr_en && wr_ch == ch_idx_t'(i)),
      .div_i(wr_div),
`ifdef TICKGEN_SYNC_EN
      .sync_i(sync_in),
`endif
      .tick_o(tick_o[i]),
      .sq_o(sq_o[i]),
      .pend_o(pend_o[i])
    );
  end
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: scoreboard bench for tick_gen_multi against a cycle-time reference model
module tb_tick_gen_multi;
  import tick_gen_pkg::*;
  localparam int NCH = 4;
  localparam int W = 24;
  localparam logic [NCH*W-1:0] INIT = {24'd12090000, 24'd30, 24'd20, 24'd48};
  typedef struct packed { logic [NCH-1:0] t, s, p; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
  logic [3:0] wr_ch = '0;
  logic [W-1:0] wr_div = '0;
`ifdef TICKGEN_SYNC_EN
  logic sync_in = 1'b0;
`endif
  logic [NCH-1:0] tick_o, sq_o, pend_o;
  int checks = 0, errors = 0;
  exp_t q[$];
  bit mon_en = 0;
  longint mc = 0, first0 = 0, n0 = 0, n3 = 0, ncyc = 1;
  longint md[NCH], ms[NCH], mst[NCH];
  bit mp[NCH];
  bit has_sync;

  always #5 clk = ~clk;

  tick_gen_multi #(.NUM_CH(NCH), .DIV_W(W), .DIV_INIT(INIT)) dut (
    .clk_In(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_div(wr_div),
`ifdef TICKGEN_SYNC_EN
    .sync_in(sync_in),
`endif
    .tick_o(tick_o),
    .sq_o(sq_o),
    .pend_o(pend_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", nm, mc, act, exp);
    end
  endtask

  // Phase of a running channel: cycles since its period last restarted, modulo its divisor.
  function automatic longint ph(int c);
    return (ncyc - mst[c]) % md[c];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      md[c] = longint'(INIT[c*W +: W]);
      ms[c] = md[c];
      mp[c] = 0;
      mst[c] = 1;
    end
    ncyc = 1;
    mc = 0;
    q.delete();
    q.push_back('0);
  endtask

  // Drives one cycle of stimulus and pushes the outputs expected in the following cycle.
  task automatic step(input bit we, input int ch, input longint dv, input bit sy);
    exp_t e = '0;
    wr_en = we;
    wr_ch = 4'(ch);
    wr_div = W'(dv);
`ifdef TICKGEN_SYNC_EN
    sync_in = sy;
`endif
    for (int c = 0; c < NCH; c++) begin
      bit en = md[c] != 0;
      bit s = sy && en;
      longint p = en ? ph(c) : 0;
      bit tc = en && p == md[c] - 1;
      e.t[c] = tc && !s;
      e.s[c] = en && !s && p < md[c] / 2;
      if (tc || s || (!en && mp[c])) begin
        md[c] = ms[c];
        mp[c] = 0;
        mst[c] = ncyc + 1;
      end
      if (we && ch == c) begin
        ms[c] = dv;
        mp[c] = 1;
        if (!en) begin
          md[c] = dv;
          mp[c] = 0;
          mst[c] = ncyc + 1;
        end
      end
      e.p[c] = mp[c];
    end
    ncyc++;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  always @(negedge clk) if (mon_en) begin
    exp_t e;
    mc++;
    if (q.size() == 0) chk("scoreboard underflow", 0, 1);
    else begin
      e = q.pop_front();
      chk("tick_o", tick_o, e.t);
      chk("sq_o", sq_o, e.s);
      chk("pend_o", pend_o, e.p);
    end
    if (mc <= 1000) begin
      if (tick_o[0] && first0 == 0) first0 = mc;
      n0 += tick_o[0];
      n3 += tick_o[3];
    end
  end

  initial begin
    int ch;
    longint dv;
    bit we, sy;
`ifdef TICKGEN_SYNC_EN
    has_sync = 1;
`else
    has_sync = 0;
`endif
    chk("div_of 250kHz", div_of(250000), 48);
    chk("div_of 40Hz", div_of(40), 302250);
    chk("div_of 30Hz", div_of(30), 403000);
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1;
    mon_en = 1;
    idle(1000);
    chk("first tick ch0 cycle", first0, 49);
    chk("ch0 ticks in 1000", n0, 20);
    chk("ch3 ticks in 1000", n3, 0);
    for (int k = 0; k < 100 && ph(0) != 20; k++) step(0, 0, 0, 0);
    step(1, 0, 10, 0);
    chk("pend0 after mid-period write", pend_o[0], 1);
    idle(80);
    step(1, 1, 0, 0);
    idle(40);
    step(1, 1, 3, 0);
    idle(30);
    for (int k = 0; k < 100 && ph(2) != md[2] - 1; k++) step(0, 0, 0, 0);
    step(1, 2, 7, 0);
    chk("ch2 tick on TC write", tick_o[2], 1);
    idle(70);
    step(1, 9, 5, 0);
    chk("pend after wr_ch 9", pend_o, 0);
    idle(20);
    step(1, 0, 1, 0);
    idle(20);
    chk("D=1 tick0 high", tick_o[0], 1);
    chk("D=1 sq0 low", sq_o[0], 0);
    mon_en = 0;
    #1 rst_n = 0;
    #1;
    chk("async reset tick_o", tick_o, 0);
    chk("async reset sq_o", sq_o, 0);
    chk("async reset pend_o", pend_o, 0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1;
    mon_en = 1;
    idle(60);
    if (has_sync) begin
      step(1, 0, 5, 0);
      step(1, 1, 7, 0);
      step(0, 0, 0, 1);
      idle($urandom_range(3, 20));
      step(0, 0, 0, 1);
      idle(80);
    end
    repeat (3000) begin
      we = $urandom_range(0, 99) < 25;
      ch = $urandom_range(0, 9) == 0 ? $urandom_range(4, 15) : $urandom_range(0, 3);
      dv = $urandom_range(0, 9) < 7 ? $urandom_range(0, 12) : $urandom_range(13, 60);
      sy = has_sync && $urandom_range(0, 49) == 0;
      step(we, ch, dv, sy);
    end
    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
